// File: rtl/chunked_adder_if.sv
// Operand/result handshake bundle for chunked_adder.
// The sub line exists only when ADDER_SUB_EN is defined.
interface chunked_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef ADDER_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`endif
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle ripple adder: CHUNK bits per clock, LSB chunk first.
// Define ADDER_SUB_EN to add the sub (a - b) operation.
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic           clk,
  input logic           rst,
  chunked_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW =
    (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST =
    IW'(NCHUNK - 1);

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad
      $error("WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE, RUN, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   add;
  logic             b_inv, c_init;

  always_comb begin
    b_inv  = 1'b0;
    c_init = bus.cin;
`ifdef ADDER_SUB_EN
    // Subtract as a + ~b + 1.
    b_inv  = bus.sub;
    c_init = bus.sub | bus.cin;
`endif
  end

  always_comb begin
    a_ch = a_q[int'(idx_q)*CHUNK +: CHUNK];
    b_ch = b_q[int'(idx_q)*CHUNK +: CHUNK];
    add  = {1'b0, a_ch} + {1'b0, b_ch}
         + {{CHUNK{1'b0}}, carry_q};

    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.a;
          b_d        = b_inv ? ~bus.b : bus.b;
          carry_d    = c_init;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*CHUNK +: CHUNK] =
          add[CHUNK-1:0];
        carry_d = add[CHUNK];
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST) begin
          cout_d = add[CHUNK];
          // a^b^s recovers the carry into the MSB.
          ovf_d  = a_ch[CHUNK-1] ^ b_ch[CHUNK-1]
                 ^ add[CHUNK-1] ^ add[CHUNK];
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder (16/4 and 8/8).
// Sub vectors are applied when ADDER_SUB_EN is defined.
module tb_chunked_adder;
  logic clk;
  logic rst;

  chunked_adder_if #(.WIDTH(16)) ifc ();
  chunked_adder_if #(.WIDTH(8))  ifc8 ();

  chunked_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  chunked_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (ifc8.slave)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_chk;
  int   n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ifc.a   = v.a;
    ifc.b   = v.b;
    ifc.cin = v.cin;
`ifdef ADDER_SUB_EN
    ifc.sub = v.sub;
`endif
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!ifc.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, ":latency"}, n, 4);
  endtask

  task automatic release_out(input string nm);
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    chk({nm, ":ov_low"}, ifc.out_valid, 0);
    chk({nm, ":ir_high"}, ifc.in_ready, 1);
  endtask

  task automatic run_op(input vec_t v,
                        input string nm);
    drive(v);
    ifc.in_valid = 1'b1;
    chk({nm, ":in_ready"}, ifc.in_ready, 1);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    wait_done(nm);
    chk({nm, ":sum"}, ifc.sum, v.sum);
    chk({nm, ":cout"}, ifc.cout, v.cout);
    chk({nm, ":ovf"}, ifc.ovf, v.ovf);
    release_out(nm);
  endtask

  initial begin
    vec_t v;
    n_chk  = 0;
    n_fail = 0;

    vecs.push_back('{16'h1234, 16'h4321, 1'b0,
      1'b0, 16'h5555, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1,
      1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0,
      1'b0, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0,
      1'b0, 16'h0000, 1'b1, 1'b1});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0,
      1'b0, 16'h1000, 1'b0, 1'b0});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0,
      1'b0, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1,
      1'b0, 16'hFFFF, 1'b1, 1'b0});
    vecs.push_back('{16'h00FF, 16'h0001, 1'b0,
      1'b0, 16'h0100, 1'b0, 1'b0});
`ifdef ADDER_SUB_EN
    vecs.push_back('{16'h0007, 16'h0005, 1'b0,
      1'b1, 16'h0002, 1'b1, 1'b0});
    vecs.push_back('{16'h0005, 16'h0007, 1'b0,
      1'b1, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{16'h0007, 16'h0005, 1'b1,
      1'b1, 16'h0002, 1'b1, 1'b0});
    vecs.push_back('{16'h8000, 16'h0001, 1'b0,
      1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif

    rst            = 1'b1;
    ifc.in_valid   = 1'b0;
    ifc.out_ready  = 1'b0;
    ifc.a          = '0;
    ifc.b          = '0;
    ifc.cin        = 1'b0;
    ifc8.in_valid  = 1'b0;
    ifc8.out_ready = 1'b0;
    ifc8.a         = '0;
    ifc8.b         = '0;
    ifc8.cin       = 1'b0;
`ifdef ADDER_SUB_EN
    ifc.sub        = 1'b0;
    ifc8.sub       = 1'b0;
`endif

    #12;
    chk("rst:in_ready", ifc.in_ready, 1);
    chk("rst:out_valid", ifc.out_valid, 0);
    chk("rst:sum", ifc.sum, 0);
    chk("rst:cout", ifc.cout, 0);
    chk("rst:ovf", ifc.ovf, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op(vecs[i], $sformatf("vec%0d", i));

    // Result held under backpressure.
    v = '{16'h1111, 16'h2222, 1'b0,
          1'b0, 16'h3333, 1'b0, 1'b0};
    drive(v);
    ifc.in_valid = 1'b1;
    @(posedge clk); #1;
    v = '{16'h0F00, 16'h0001, 1'b0,
          1'b0, 16'h0F01, 1'b0, 1'b0};
    drive(v);
    wait_done("hold");
    chk("hold:sum0", ifc.sum, 16'h3333);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold:ov", ifc.out_valid, 1);
      chk("hold:sum", ifc.sum, 16'h3333);
      chk("hold:ir", ifc.in_ready, 0);
    end
    release_out("hold");
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    chk("hold:taken", ifc.in_ready, 0);
    wait_done("hold2");
    chk("hold2:sum", ifc.sum, 16'h0F01);
    chk("hold2:cout", ifc.cout, 0);
    release_out("hold2");

    // Full-width single-chunk adder.
    ifc8.a        = 8'hFF;
    ifc8.b        = 8'h01;
    ifc8.in_valid = 1'b1;
    chk("w8:ir", ifc8.in_ready, 1);
    @(posedge clk); #1;
    ifc8.in_valid = 1'b0;
    chk("w8:ov0", ifc8.out_valid, 0);
    @(posedge clk); #1;
    chk("w8:ov1", ifc8.out_valid, 1);
    chk("w8:sum", ifc8.sum, 8'h00);
    chk("w8:cout", ifc8.cout, 1);
    chk("w8:ovf", ifc8.ovf, 0);
    ifc8.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc8.out_ready = 1'b0;
    chk("w8:done", ifc8.out_valid, 0);

    // Reset in the middle of RUN.
    v = '{16'hFFFF, 16'hFFFF, 1'b1,
          1'b0, 16'hFFFF, 1'b1, 1'b0};
    drive(v);
    ifc.in_valid = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("abort:ov", ifc.out_valid, 0);
    chk("abort:ir", ifc.in_ready, 1);
    chk("abort:sum", ifc.sum, 0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort:ov2", ifc.out_valid, 0);
    v = '{16'h0F0F, 16'h00F1, 1'b0,
          1'b0, 16'h1000, 1'b0, 1'b0};
    run_op(v, "after_abort");

    $display(
      "End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end
endmodule
